// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage pipeline.
// Drives latch and PC controls and keeps cycle/stall statistics.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_redirect,
    input  logic             mem_halt,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wreg,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_wen,
    output logic             idex_flush,
    output logic             exmem_wen,
    output logic             exmem_flush,
    output logic             memwb_wen,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   halt_entry_q;
    logic   back_ok;
    logic   front_ok;
    logic   luse;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign back_ok  = dhit | ~(mem_dREN | mem_dWEN);
    assign front_ok = ihit;
    assign luse     = ex_dREN & (ex_wreg != 5'd0)
                    & ((ex_wreg == id_rs) | (ex_wreg == id_rt));

    // Next state and latch controls from current inputs and state.
    always_comb begin
        state_d     = state_q;
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        ifid_flush  = 1'b0;
        idex_wen    = 1'b0;
        idex_flush  = 1'b0;
        exmem_wen   = 1'b0;
        exmem_flush = 1'b0;
        memwb_wen   = 1'b0;
        memwb_flush = 1'b0;
        if (state_q == HALTED) begin
            // One-shot clear of MEM/WB once the HALT has retired.
            memwb_flush = halt_entry_q;
        end else begin
            if (!back_ok) begin
                state_d = MEMWAIT;
            end else if (mem_halt) begin
                state_d = HALTED;
            end else begin
                state_d = RUN;
            end
            if (!back_ok) begin
                pc_wen = 1'b0;
            end else if (mem_redirect) begin
                pc_wen      = 1'b1;
                memwb_wen   = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (!front_ok) begin
                memwb_wen   = 1'b1;
                exmem_flush = 1'b1;
            end else if (luse) begin
                memwb_wen  = 1'b1;
                exmem_wen  = 1'b1;
                idex_flush = 1'b1;
            end else begin
                pc_wen    = 1'b1;
                ifid_wen  = 1'b1;
                idex_wen  = 1'b1;
                exmem_wen = 1'b1;
                memwb_wen = 1'b1;
            end
        end
    end

    // State register and halt-entry marker.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= RUN;
            halt_entry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_entry_q <= (state_q != HALTED) && (state_d == HALTED);
        end
    end

    assign halted = (state_q == HALTED);

    // Saturating statistics, frozen once halted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else if (state_q != HALTED) begin
            if (cyc_cnt != CNT_MAX) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            if (!pc_wen && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of the stall/flush sequencer.
// A narrow-counter instance covers saturation.
module tb_pipeline_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, mem_dREN, mem_dWEN;
    logic       mem_redirect, mem_halt, ex_dREN;
    logic [4:0] ex_wreg, id_rs, id_rt;

    logic        pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush;
    logic        exmem_wen, exmem_flush, memwb_wen, memwb_flush, halted;
    logic [31:0] cyc_cnt, stall_cnt;

    logic       s_pc_wen, s_ifid_wen, s_ifid_flush, s_idex_wen;
    logic       s_idex_flush, s_exmem_wen, s_exmem_flush;
    logic       s_memwb_wen, s_memwb_flush, s_halted;
    logic [3:0] s_cyc_cnt, s_stall_cnt;

    logic [4:0] wens;
    logic [3:0] fl;

    int checks   = 0;
    int failures = 0;

    assign wens = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen};
    assign fl   = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .mem_redirect(mem_redirect), .mem_halt(mem_halt),
        .ex_dREN(ex_dREN), .ex_wreg(ex_wreg),
        .id_rs(id_rs), .id_rt(id_rt),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idex_wen(idex_wen), .idex_flush(idex_flush),
        .exmem_wen(exmem_wen), .exmem_flush(exmem_flush),
        .memwb_wen(memwb_wen), .memwb_flush(memwb_flush),
        .halted(halted), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) sat (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .mem_redirect(mem_redirect), .mem_halt(mem_halt),
        .ex_dREN(ex_dREN), .ex_wreg(ex_wreg),
        .id_rs(id_rs), .id_rt(id_rt),
        .pc_wen(s_pc_wen), .ifid_wen(s_ifid_wen),
        .ifid_flush(s_ifid_flush),
        .idex_wen(s_idex_wen), .idex_flush(s_idex_flush),
        .exmem_wen(s_exmem_wen), .exmem_flush(s_exmem_flush),
        .memwb_wen(s_memwb_wen), .memwb_flush(s_memwb_flush),
        .halted(s_halted), .cyc_cnt(s_cyc_cnt),
        .stall_cnt(s_stall_cnt)
    );

    task automatic set_idle();
        ihit = 1'b1; dhit = 1'b0;
        mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_redirect = 1'b0; mem_halt = 1'b0;
        ex_dREN = 1'b0; ex_wreg = 5'd0;
        id_rs = 5'd0; id_rt = 5'd0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        RST = 1'b1;
        #1;
        checks++;
        if (wens !== 5'b11111 || fl !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs wens=%b fl=%b want 11111/0000",
                     wens, fl);
        end
        tick();
        tick();
        RST = 1'b0;
        checks++;
        if (cyc_cnt !== 32'd0 || stall_cnt !== 32'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state cyc=%0d stall=%0d halted=%b want 0/0/0",
                     cyc_cnt, stall_cnt, halted);
        end
    endtask

    task automatic test_straight_line();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (wens !== 5'b11111 || fl !== 4'b0000) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL straight_wens bad_cycles=%0d want 0", bad);
        end
        checks++;
        if (cyc_cnt !== 32'd10 || stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL straight_cnt cyc=%0d stall=%0d want 10/0",
                     cyc_cnt, stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_dREN = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
        #1;
        checks++;
        if (wens !== 5'b00011 || fl !== 4'b0100) begin
            failures++;
            $display("FAIL luse_stall wens=%b fl=%b want 00011/0100",
                     wens, fl);
        end
        tick();
        ex_dREN = 1'b0;
        #1;
        checks++;
        if (wens !== 5'b11111 || fl !== 4'b0000) begin
            failures++;
            $display("FAIL luse_after wens=%b fl=%b want 11111/0000",
                     wens, fl);
        end
        tick();
        checks++;
        if (stall_cnt !== 32'd1 || cyc_cnt !== 32'd2) begin
            failures++;
            $display("FAIL luse_cnt stall=%0d cyc=%0d want 1/2",
                     stall_cnt, cyc_cnt);
        end
        ex_dREN = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        checks++;
        if (wens !== 5'b11111 || fl !== 4'b0000) begin
            failures++;
            $display("FAIL luse_r0 wens=%b fl=%b want 11111/0000",
                     wens, fl);
        end
        ex_wreg = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        #1;
        checks++;
        if (wens !== 5'b00011 || fl !== 4'b0100) begin
            failures++;
            $display("FAIL luse_rt wens=%b fl=%b want 00011/0100",
                     wens, fl);
        end
        tick();
    endtask

    task automatic test_data_miss();
        int bad = 0;
        do_reset();
        mem_dREN = 1'b1; dhit = 1'b0; ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (wens !== 5'b00000 || fl !== 4'b0000) bad++;
            tick();
            if (dut.state_q !== 2'd1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL miss_freeze bad=%0d want 0", bad);
        end
        dhit = 1'b1; ihit = 1'b1;
        #1;
        checks++;
        if (wens !== 5'b11111 || fl !== 4'b0000) begin
            failures++;
            $display("FAIL miss_release wens=%b fl=%b want 11111/0000",
                     wens, fl);
        end
        tick();
        checks++;
        if (dut.state_q !== 2'd0 || stall_cnt !== 32'd3 || cyc_cnt !== 32'd4) begin
            failures++;
            $display("FAIL miss_cnt state=%0d stall=%0d cyc=%0d want 0/3/4",
                     dut.state_q, stall_cnt, cyc_cnt);
        end
        mem_dREN = 1'b0; mem_dWEN = 1'b1; dhit = 1'b1; ihit = 1'b0;
        #1;
        checks++;
        if (wens !== 5'b00001 || fl !== 4'b0010) begin
            failures++;
            $display("FAIL store_hit_imiss wens=%b fl=%b want 00001/0010",
                     wens, fl);
        end
        mem_dWEN = 1'b0; dhit = 1'b0;
        mem_dREN = 1'b1; RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (dut.state_q !== 2'd0 || cyc_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_freeze state=%0d cyc=%0d want 0/0",
                     dut.state_q, cyc_cnt);
        end
        set_idle();
    endtask

    task automatic test_redirect();
        do_reset();
        mem_redirect = 1'b1; ihit = 1'b0;
        #1;
        checks++;
        if (wens !== 5'b10001 || fl !== 4'b1110) begin
            failures++;
            $display("FAIL redirect_imiss wens=%b fl=%b want 10001/1110",
                     wens, fl);
        end
        ihit = 1'b1; ex_dREN = 1'b1; ex_wreg = 5'd4; id_rt = 5'd4;
        #1;
        checks++;
        if (wens !== 5'b10001 || fl !== 4'b1110) begin
            failures++;
            $display("FAIL redirect_luse wens=%b fl=%b want 10001/1110",
                     wens, fl);
        end
        mem_dREN = 1'b1; dhit = 1'b0;
        #1;
        checks++;
        if (wens !== 5'b00000 || fl !== 4'b0000) begin
            failures++;
            $display("FAIL redirect_dmiss wens=%b fl=%b want 00000/0000",
                     wens, fl);
        end
        set_idle();
        ihit = 1'b0;
        #1;
        checks++;
        if (wens !== 5'b00001 || fl !== 4'b0010) begin
            failures++;
            $display("FAIL imiss wens=%b fl=%b want 00001/0010",
                     wens, fl);
        end
        tick();
        checks++;
        if (stall_cnt !== 32'd1 || cyc_cnt !== 32'd1) begin
            failures++;
            $display("FAIL imiss_cnt stall=%0d cyc=%0d want 1/1",
                     stall_cnt, cyc_cnt);
        end
        set_idle();
    endtask

    task automatic test_halt();
        int bad = 0;
        do_reset();
        mem_halt = 1'b1; mem_dREN = 1'b1; dhit = 1'b0;
        #1;
        checks++;
        if (wens !== 5'b00000) begin
            failures++;
            $display("FAIL halt_wait wens=%b want 00000", wens);
        end
        tick();
        checks++;
        if (halted !== 1'b0 || dut.state_q !== 2'd1) begin
            failures++;
            $display("FAIL halt_wait_state halted=%b state=%0d want 0/1",
                     halted, dut.state_q);
        end
        mem_dREN = 1'b0; dhit = 1'b0;
        #1;
        checks++;
        if (memwb_wen !== 1'b1 || memwb_flush !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_adv memwb_wen=%b memwb_flush=%b halted=%b want 1/0/0",
                     memwb_wen, memwb_flush, halted);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || cyc_cnt !== 32'd2 || stall_cnt !== 32'd1) begin
            failures++;
            $display("FAIL halted_rise halted=%b cyc=%0d stall=%0d want 1/2/1",
                     halted, cyc_cnt, stall_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            ihit = i[0]; mem_redirect = i[1]; mem_dREN = i[2];
            dhit = i[3]; mem_halt = 1'b0;
            #1;
            if (wens !== 5'b00000 || halted !== 1'b1) bad++;
            if (i > 0 && fl !== 4'b0000) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halted_hold bad=%0d want 0", bad);
        end
        checks++;
        if (cyc_cnt !== 32'd2 || stall_cnt !== 32'd1) begin
            failures++;
            $display("FAIL halted_freeze cyc=%0d stall=%0d want 2/1",
                     cyc_cnt, stall_cnt);
        end
        do_reset();
        checks++;
        if (halted !== 1'b0 || cyc_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL halt_reset halted=%b cyc=%0d stall=%0d want 0/0/0",
                     halted, cyc_cnt, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (s_cyc_cnt !== 4'hF || s_stall_cnt !== 4'h0 || cyc_cnt !== 32'd20) begin
            failures++;
            $display("FAIL sat_cyc s_cyc=%0d s_stall=%0d cyc=%0d want 15/0/20",
                     s_cyc_cnt, s_stall_cnt, cyc_cnt);
        end
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (s_cyc_cnt !== 4'hF || s_stall_cnt !== 4'hF || stall_cnt !== 32'd20) begin
            failures++;
            $display("FAIL sat_stall s_cyc=%0d s_stall=%0d stall=%0d want 15/15/20",
                     s_cyc_cnt, s_stall_cnt, stall_cnt);
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        RST = 1'b1;
        test_reset();
        test_straight_line();
        test_load_use();
        test_data_miss();
        test_redirect();
        test_halt();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
